cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
Sits between the split L1 caches (icache, dcache) and the single 256-bit cacheline memory port that the testbench memory model serves.
Grants one cache at a time, issues a registered line read or write to memory, and returns the response pulse and read data to the granted cache.
Directly drives mem_read/mem_write/mem_address/mem_wdata and consumes mem_resp/mem_rdata.

Parameters:
LINE_W, 256, cacheline width in bits
ADDR_W, 32, byte address width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  reset, synchronous, active-high
i_read  in  1  icache line-fill request, level, held until i_resp
i_address  in  ADDR_W  icache line address (bits [4:0] ignored)
i_resp  out  1  one-cycle completion pulse to icache
i_rdata  out  LINE_W  fill data, valid only while i_resp=1
d_read  in  1  dcache line-fill request, level
d_write  in  1  dcache writeback request, level
d_address  in  ADDR_W  dcache line address
d_wdata  in  LINE_W  dcache writeback data
d_resp  out  1  one-cycle completion pulse to dcache
d_rdata  out  LINE_W  fill data, valid only while d_resp=1
mem_read  out  1  memory read request (registered)
mem_write  out  1  memory write request (registered)
mem_address  out  ADDR_W  line address to memory, [4:0] forced to 0
mem_wdata  out  LINE_W  writeback data to memory
mem_resp  in  1  memory completion pulse
mem_rdata  in  LINE_W  memory read data, valid with mem_resp

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: state=IDLE; mem_read=0, mem_write=0, mem_address=0, mem_wdata=0; i_resp=0, d_resp=0; last_grant=I.
- FSM states: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE: sample requests.
  - d_read|d_write and no i_read -> D_BUSY.
  - i_read only -> I_BUSY.
  - Both -> dcache wins (fixed priority).
  - At the grant edge, latch the address (with [4:0]=0) and wdata into output registers and set mem_read or mem_write. Memory sees the request one cycle after the cache raises it.
- dcache read+write both high: write wins; mem_write=1, mem_read=0.
- I_BUSY/D_BUSY: hold mem_* outputs stable until mem_resp=1.
  - On that cycle, drive the granted cache's *_resp=1 combinationally from mem_resp; *_rdata = mem_rdata (passthrough, zero latency).
  - At the same edge, clear mem_read/mem_write and go to DONE.
  - The non-granted cache's resp stays 0.
- DONE: one mandatory bubble cycle (no grant) so the served cache can drop its request; then IDLE. Minimum back-to-back service = 1 issue + N memory + 1 bubble cycles.
- mem_resp in IDLE or DONE: ignored, never forwarded.
- i_rdata/d_rdata when the respective resp=0: drive mem_rdata (don't-care for consumers; no gating required).
- Request dropped by a cache mid-transaction: the transaction still completes to memory; the resp pulse is still issued.
- rst mid-transaction: next edge forces IDLE and deasserts mem_read/mem_write. Any later mem_resp for the aborted access is ignored.

Optional Feature:
ARB_RR_EN — when defined, arbitration on simultaneous icache/dcache requests alternates.
- Whichever side was not in last_grant wins.
- last_grant updates on every grant.
When undefined, fixed dcache-first priority; last_grant is not implemented.

Decomposition:
- Shared package cache_arb_pkg holds:
  - enum arb_state_t {IDLE, I_BUSY, D_BUSY, DONE};
  - enum grant_t {GRANT_I, GRANT_D};
  - localparams LINE_W=256, OFFSET_BITS=5.
- No sub-module; the FSM, output registers and response mux fit in one module.

Test Plan:
- i_read=1, i_address=0x0000_0064; memory responds 3 cycles after mem_read -> mem_read=1 with mem_address=0x0000_0060 one cycle after the request; i_resp=1 for exactly one cycle with i_rdata=mem_rdata; d_resp stays 0.
- d_write=1, d_address=0x0000_1000, d_wdata=256'hA5.. -> mem_write=1, mem_wdata=256'hA5.., held until mem_resp; d_resp pulses once; DONE bubble seen before the next grant.
- i_read and d_read raised in the same cycle (fixed priority) -> dcache is served first, then icache.
- Same stimulus with ARB_RR_EN -> grants alternate I, D, I, D over four repeated collisions.
- d_read=d_write=1 -> only mem_write asserts.
- Spurious mem_resp in IDLE -> no i_resp/d_resp.
- rst asserted while in I_BUSY -> next cycle mem_read=0, state IDLE; a subsequent mem_resp does not produce i_resp.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the L1 cache-to-memory arbiter.
package cache_arb_pkg;

  localparam int LINE_W      = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbiter between the split L1 caches and the single cacheline memory port.
// One cache is granted at a time; the memory request is registered, the
// response pulse and read data are passed straight back to the granted cache,
// and a one-cycle bubble follows every transaction.
// Optional build macro: ARB_RR_EN -- alternate grants on simultaneous
// icache/dcache requests instead of fixed dcache-first priority.
module cache_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata
);

  import cache_arb_pkg::*;

  arb_state_t        state_r;
  arb_state_t        state_s;
  logic              d_req_s;
  logic              i_req_s;
  logic              pick_d_s;
  logic [ADDR_W-1:0] i_line_s;
  logic [ADDR_W-1:0] d_line_s;
  logic              unused_s;

`ifdef ARB_RR_EN
  grant_t            last_grant_r;
`endif

  // Line-align addresses; the byte offset within a line never reaches memory.
  assign i_line_s = {i_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign d_line_s = {d_address[ADDR_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign unused_s = ^{i_address[OFFSET_BITS-1:0], d_address[OFFSET_BITS-1:0]};

  // Request decode and tie-break between the two caches.
  always_comb begin
    d_req_s = d_read | d_write;
    i_req_s = i_read;
`ifdef ARB_RR_EN
    if (d_req_s && i_req_s) begin
      pick_d_s = (last_grant_r == GRANT_I);
    end else begin
      pick_d_s = d_req_s;
    end
`else
    pick_d_s = d_req_s;
`endif
  end

  // Next-state logic: grant from IDLE, wait for memory, then one bubble.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_d_s) begin
          state_s = D_BUSY;
        end else if (i_req_s) begin
          state_s = I_BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Response forwarding: only the granted cache sees mem_resp, data passes through.
  always_comb begin
    i_resp  = (state_r == I_BUSY) && mem_resp;
    d_resp  = (state_r == D_BUSY) && mem_resp;
    i_rdata = mem_rdata;
    d_rdata = mem_rdata;
  end

  // State register and registered memory request held until mem_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= {ADDR_W{1'b0}};
      mem_wdata   <= {LINE_W{1'b0}};
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (pick_d_s) begin
            // A writeback beats a fill when the dcache raises both.
            mem_address <= d_line_s;
            mem_wdata   <= d_wdata;
            mem_write   <= d_write;
            mem_read    <= ~d_write;
          end else if (i_req_s) begin
            mem_address <= i_line_s;
            mem_read    <= 1'b1;
            mem_write   <= 1'b0;
          end else begin
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
          end
        end
        I_BUSY, D_BUSY: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        DONE: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
        default: begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARB_RR_EN
  // Remember the side granted last so a collision goes to the other side.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= GRANT_I;
    end else if ((state_r == IDLE) && pick_d_s) begin
      last_grant_r <= GRANT_D;
    end else if ((state_r == IDLE) && i_req_s) begin
      last_grant_r <= GRANT_I;
    end
  end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter. Inputs change and outputs
// are sampled around the falling clock edge; expected values are hand-derived.
module tb_cache_arbiter;

  logic         clk;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_address;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata;
  logic         mem_resp;
  logic [255:0] mem_rdata;

  int checks;
  int failures;

  cache_arbiter #(.LINE_W(256), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_read     (i_read),
    .i_address  (i_address),
    .i_resp     (i_resp),
    .i_rdata    (i_rdata),
    .d_read     (d_read),
    .d_write    (d_write),
    .d_address  (d_address),
    .d_wdata    (d_wdata),
    .d_resp     (d_resp),
    .d_rdata    (d_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Called at a falling edge in IDLE with the request already applied.
  // Checks the grant, holds for lat cycles, pulses mem_resp, then checks
  // the DONE bubble. Returns at the falling edge of the following IDLE cycle.
  task automatic serve(input logic exp_d, input logic exp_wr, input logic [31:0] exp_addr,
                       input logic [255:0] exp_wd, input int lat, input logic [255:0] data);
    @(negedge clk); #1;
    chk("grant_mem_read",  mem_read,  !exp_wr);
    chk("grant_mem_write", mem_write, exp_wr);
    chk("grant_mem_address", mem_address, exp_addr);
    if (exp_wr) chk("grant_mem_wdata", mem_wdata, exp_wd);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk); #1;
      chk("hold_mem_read",  mem_read,  !exp_wr);
      chk("hold_mem_write", mem_write, exp_wr);
      chk("hold_i_resp", i_resp, 1'b0);
      chk("hold_d_resp", d_resp, 1'b0);
    end
    mem_resp  = 1'b1;
    mem_rdata = data;
    #1;
    chk("resp_i_resp", i_resp, !exp_d);
    chk("resp_d_resp", d_resp, exp_d);
    if (exp_d) chk("resp_d_rdata", d_rdata, data);
    else       chk("resp_i_rdata", i_rdata, data);
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = 256'h0;
    #1;
    chk("done_mem_read",  mem_read,  1'b0);
    chk("done_mem_write", mem_write, 1'b0);
    chk("done_i_resp", i_resp, 1'b0);
    chk("done_d_resp", d_resp, 1'b0);
    @(negedge clk); #1;
    chk("bubble_mem_read",  mem_read,  1'b0);
    chk("bubble_mem_write", mem_write, 1'b0);
  endtask

  initial begin
    logic         exp_d;
    logic [255:0] wd_a5;
    checks    = 0;
    failures  = 0;
    wd_a5     = {32{8'hA5}};
    rst       = 1'b1;
    i_read    = 1'b0;
    i_address = 32'h0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = 32'h0;
    d_wdata   = 256'h0;
    mem_resp  = 1'b0;
    mem_rdata = 256'h0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_read",    mem_read,    1'b0);
    chk("rst_mem_write",   mem_write,   1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_mem_wdata",   mem_wdata,   256'h0);
    chk("rst_i_resp",      i_resp,      1'b0);
    chk("rst_d_resp",      d_resp,      1'b0);

    // icache fill, offset bits dropped, memory answers after 3 cycles
    rst       = 1'b0;
    i_read    = 1'b1;
    i_address = 32'h0000_0064;
    #1;
    chk("pre_grant_mem_read", mem_read, 1'b0);
    serve(1'b0, 1'b0, 32'h0000_0060, 256'h0, 3, {8{32'h1111_2222}});
    i_read = 1'b0;

    // dcache writeback, held for the bubble, then granted again
    d_write   = 1'b1;
    d_address = 32'h0000_1000;
    d_wdata   = wd_a5;
    serve(1'b1, 1'b1, 32'h0000_1000, wd_a5, 2, {8{32'h3333_4444}});
    d_address = 32'h0000_1020;
    d_wdata   = {32{8'h5A}};
    // request dropped mid-transaction still completes with a pulse
    @(negedge clk); #1;
    chk("regrant_mem_write",   mem_write,   1'b1);
    chk("regrant_mem_address", mem_address, 32'h0000_1020);
    chk("regrant_mem_wdata",   mem_wdata,   {32{8'h5A}});
    d_write = 1'b0;
    @(negedge clk); #1;
    chk("dropped_mem_write_held", mem_write, 1'b1);
    mem_resp = 1'b1;
    #1;
    chk("dropped_d_resp", d_resp, 1'b1);
    chk("dropped_i_resp", i_resp, 1'b0);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    chk("dropped_done_mem_write", mem_write, 1'b0);
    @(negedge clk); #1;

    // dcache read and write together: write only
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_2047;
    d_wdata   = {8{32'hDEAD_BEEF}};
    serve(1'b1, 1'b1, 32'h0000_2040, {8{32'hDEAD_BEEF}}, 2, {8{32'h5555_6666}});
    d_read  = 1'b0;
    d_write = 1'b0;

    // Spurious mem_resp in IDLE
    mem_resp  = 1'b1;
    mem_rdata = {8{32'h7777_8888}};
    #1;
    chk("spurious_i_resp", i_resp, 1'b0);
    chk("spurious_d_resp", d_resp, 1'b0);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    chk("spurious_mem_read",  mem_read,  1'b0);
    chk("spurious_mem_write", mem_write, 1'b0);

    // Four collisions with both fills held; last grant so far was dcache
    i_read    = 1'b1;
    d_read    = 1'b1;
    i_address = 32'h0000_0200;
    d_address = 32'h0000_0300;
    for (int r = 0; r < 4; r++) begin
`ifdef ARB_RR_EN
      exp_d = r[0];
`else
      exp_d = 1'b1;
`endif
      serve(exp_d, 1'b0, exp_d ? 32'h0000_0300 : 32'h0000_0200, 256'h0, 1, {8{32'hC0DE_0000 + r}});
    end
    d_read = 1'b0;
    serve(1'b0, 1'b0, 32'h0000_0200, 256'h0, 1, {8{32'hC0DE_00FF}});
    i_read = 1'b0;

    // Reset during an icache fill aborts it
    i_read    = 1'b1;
    i_address = 32'h0000_0400;
    @(negedge clk); #1;
    chk("abort_grant_mem_read", mem_read, 1'b1);
    chk("abort_grant_address",  mem_address, 32'h0000_0400);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("abort_mem_read", mem_read, 1'b0);
    rst      = 1'b0;
    i_read   = 1'b0;
    mem_resp = 1'b1;
    #1;
    chk("abort_late_i_resp", i_resp, 1'b0);
    @(negedge clk);
    mem_resp = 1'b0;
    #1;
    chk("abort_idle_mem_read", mem_read, 1'b0);
    // A new dcache request is granted at once, so the arbiter is in IDLE
    d_read    = 1'b1;
    d_address = 32'h0000_0500;
    serve(1'b1, 1'b0, 32'h0000_0500, 256'h0, 1, {8{32'h9999_AAAA}});
    d_read = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
